// File: rtl/param_load_if.sv
// -----------------------------------------------------------------------------
// param_load_if
// Stream bundle between the external loader, the parameter load sequencer and
// the downstream 1-to-3 parameter demultiplexer.
//
//   s_data / s_valid / s_ready       : incoming word stream from the loader
//   sel / out_data / out_valid       : tagged word toward the demux
//   out_ready                        : downstream buffer can take out_data
//
// Modports:
//   slave  : the sequencer (consumes s_*, produces sel/out_data/out_valid)
//   master : the environment around it (loader + demux side)
// -----------------------------------------------------------------------------
interface param_load_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  out_ready;
  logic [1:0]            sel;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;

  modport slave (
    input  s_data, s_valid, out_ready,
    output s_ready, sel, out_data, out_valid
  );

  modport master (
    output s_data, s_valid, out_ready,
    input  s_ready, sel, out_data, out_valid
  );
endinterface

// File: rtl/param_load_sequencer.sv
// -----------------------------------------------------------------------------
// param_load_sequencer
// Front-end load controller for the parameter demultiplexer. A single
// valid/ready word stream is tagged BIAS, then WGT, then IFM by counting
// against region lengths latched on start. Tagged words leave through a
// one-deep registered output stage (1 cycle latency, 1 word/cycle). Regions
// with zero length are skipped; after the last word has left the output
// stage, done pulses for one cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a load (sampled only in IDLE)
//   num_bias/wgt/ifm      region word counts, latched on start
//   bus (slave modport)   s_data/s_valid/s_ready in, sel/out_data/out_valid
//                         /out_ready toward the demux
//   busy                  high whenever the sequencer is not IDLE
//   done                  one-cycle pulse at the end of a load
//
// Optional build macro PARAM_LOAD_SEQ_STATUS_EN adds:
//   err_start             sticky: start seen while busy; cleared by next
//                         accepted start
//   words_loaded          output handshakes of the current load; cleared by
//                         accepted start, held after done
// -----------------------------------------------------------------------------
module param_load_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter int         CNT_WIDTH  = 16,
  parameter logic [1:0] IFM        = 2'b01,
  parameter logic [1:0] WGT        = 2'b10,
  parameter logic [1:0] BIAS       = 2'b11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_bias,
  input  logic [CNT_WIDTH-1:0] num_wgt,
  input  logic [CNT_WIDTH-1:0] num_ifm,
  param_load_if.slave          bus,
  output logic                 busy,
  output logic                 done
`ifdef PARAM_LOAD_SEQ_STATUS_EN
  ,
  output logic                 err_start,
  output logic [CNT_WIDTH+1:0] words_loaded
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_BIAS,
    S_LD_WGT,
    S_LD_IFM,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  rem_bias;
  logic [CNT_WIDTH-1:0]  rem_wgt;
  logic [CNT_WIDTH-1:0]  rem_ifm;

  logic [DATA_WIDTH-1:0] out_data_p0;
  logic [1:0]            sel_p0;
  logic                  vld_p0;

  logic                  in_load;
  logic                  last_word;
  logic [1:0]            phase_code;
  logic                  s_ready_int;
  logic                  s_hs;
  logic                  o_hs;

  // First region (in fixed BIAS, WGT, IFM order) that still has words;
  // DRAIN when none do.
  function automatic state_t route(input logic has_bias,
                                   input logic has_wgt,
                                   input logic has_ifm);
    if (has_bias)     return S_LD_BIAS;
    else if (has_wgt) return S_LD_WGT;
    else if (has_ifm) return S_LD_IFM;
    else              return S_DRAIN;
  endfunction

  always_comb begin
    in_load    = 1'b0;
    last_word  = 1'b0;
    phase_code = 2'b00;
    case (state)
      S_LD_BIAS: begin
        in_load    = 1'b1;
        last_word  = (rem_bias == CNT_ONE);
        phase_code = BIAS;
      end
      S_LD_WGT: begin
        in_load    = 1'b1;
        last_word  = (rem_wgt == CNT_ONE);
        phase_code = WGT;
      end
      S_LD_IFM: begin
        in_load    = 1'b1;
        last_word  = (rem_ifm == CNT_ONE);
        phase_code = IFM;
      end
      default: ;
    endcase
  end

  // Accept a word only when the output slot is empty or being emptied now.
  assign s_ready_int = in_load && (!vld_p0 || bus.out_ready);
  assign s_hs        = s_ready_int && bus.s_valid;
  assign o_hs        = vld_p0 && bus.out_ready;

  assign bus.s_ready   = s_ready_int;
  assign bus.sel       = sel_p0;
  assign bus.out_data  = out_data_p0;
  assign bus.out_valid = vld_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rem_bias    <= '0;
      rem_wgt     <= '0;
      rem_ifm     <= '0;
      out_data_p0 <= '0;
      sel_p0      <= 2'b00;
      vld_p0      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;

      // ---- stage p0: registered output toward the demux ----
      if (s_hs) begin
        out_data_p0 <= bus.s_data;
        sel_p0      <= phase_code;
        vld_p0      <= 1'b1;
      end else if (o_hs) begin
        out_data_p0 <= '0;
        sel_p0      <= 2'b00;
        vld_p0      <= 1'b0;
      end

      // ---- sequencing ----
      case (state)
        S_IDLE: begin
          if (start) begin
            rem_bias <= num_bias;
            rem_wgt  <= num_wgt;
            rem_ifm  <= num_ifm;
            state    <= route(num_bias != '0, num_wgt != '0, num_ifm != '0);
            busy     <= 1'b1;
          end
        end
        S_LD_BIAS: begin
          if (s_hs) begin
            rem_bias <= rem_bias - CNT_ONE;
            if (last_word) state <= route(1'b0, rem_wgt != '0, rem_ifm != '0);
          end
        end
        S_LD_WGT: begin
          if (s_hs) begin
            rem_wgt <= rem_wgt - CNT_ONE;
            if (last_word) state <= route(1'b0, 1'b0, rem_ifm != '0);
          end
        end
        S_LD_IFM: begin
          if (s_hs) begin
            rem_ifm <= rem_ifm - CNT_ONE;
            if (last_word) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Finish only once the last word has left (or is leaving) p0.
          if (!vld_p0 || bus.out_ready) begin
            state <= S_FIN;
            done  <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARAM_LOAD_SEQ_STATUS_EN
  localparam logic [CNT_WIDTH+1:0] WL_ONE = {{(CNT_WIDTH+1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_start    <= 1'b0;
      words_loaded <= '0;
    end else if (state == S_IDLE && start) begin
      err_start    <= 1'b0;
      words_loaded <= '0;
    end else begin
      if (start && busy) err_start <= 1'b1;
      if (o_hs)          words_loaded <= words_loaded + WL_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_param_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_param_load_sequencer
// Directed bench for param_load_sequencer. Inputs change and outputs are
// sampled 1 time unit after the rising clock edge. Build with
// +define+PARAM_LOAD_SEQ_STATUS_EN to exercise the status outputs as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_param_load_sequencer;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_bias, num_wgt, num_ifm;
  logic          busy, done;
`ifdef PARAM_LOAD_SEQ_STATUS_EN
  logic          err_start;
  logic [CW+1:0] words_loaded;
`endif

  int total = 0;
  int bad   = 0;

  param_load_if #(.DATA_WIDTH(DW)) bus ();

  param_load_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_bias     (num_bias),
    .num_wgt      (num_wgt),
    .num_ifm      (num_ifm),
    .bus          (bus),
    .busy         (busy),
    .done         (done)
`ifdef PARAM_LOAD_SEQ_STATUS_EN
    ,
    .err_start    (err_start),
    .words_loaded (words_loaded)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [1:0] s,
                         input logic [31:0] d);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
    chk({tag, ".sel"},       32'(bus.sel),       32'(s));
    chk({tag, ".out_data"},  bus.out_data,       d);
  endtask

  task automatic do_start(input int b, input int w, input int i);
    num_bias = CW'(b);
    num_wgt  = CW'(w);
    num_ifm  = CW'(i);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    int exp_sel [9] = '{3, 3, 2, 2, 2, 1, 1, 1, 1};

    rst_n         = 1'b0;
    start         = 1'b0;
    num_bias      = '0;
    num_wgt       = '0;
    num_ifm       = '0;
    bus.s_data    = '0;
    bus.s_valid   = 1'b0;
    bus.out_ready = 1'b1;

    // ---- reset state ----
    #12;
    chk_out("rst", 1'b0, 2'b00, 32'h0);
    chk("rst.s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst.busy",    32'(busy),        32'd0);
    chk("rst.done",    32'(done),        32'd0);
    #5 rst_n = 1'b1;
    tick();

    // ---- 2/3/4 streaming, back-to-back ----
    do_start(2, 3, 4);
    chk("t1.busy", 32'(busy), 32'd1);
    bus.s_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      bus.s_data = 32'(k);
      #1;
      chk($sformatf("t1.s_ready%0d", k), 32'(bus.s_ready), 32'd1);
      tick();
      chk_out($sformatf("t1.beat%0d", k), 1'b1, 2'(exp_sel[k-1]), 32'(k));
    end
    bus.s_valid = 1'b0;
    chk("t1.done_early", 32'(done), 32'd0);
    tick();
    chk("t1.done",  32'(done), 32'd1);
    chk("t1.busy_fin", 32'(busy), 32'd1);
    chk_out("t1.drained", 1'b0, 2'b00, 32'h0);
    tick();
    chk("t1.done_end", 32'(done), 32'd0);
    chk("t1.busy_end", 32'(busy), 32'd0);

    // ---- 0/2/0: only WGT beats ----
    do_start(0, 2, 0);
    chk_out("t2.idle_out", 1'b0, 2'b00, 32'h0);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hA0;
    tick();
    chk_out("t2.beat1", 1'b1, 2'b10, 32'hA0);
    bus.s_data  = 32'hA1;
    tick();
    chk_out("t2.beat2", 1'b1, 2'b10, 32'hA1);
    bus.s_valid = 1'b0;
    tick();
    chk("t2.done", 32'(done), 32'd1);
    chk_out("t2.after", 1'b0, 2'b00, 32'h0);
    tick();
    chk("t2.busy_end", 32'(busy), 32'd0);

    // ---- all counts zero ----
    do_start(0, 0, 0);
    chk("t3.busy1", 32'(busy), 32'd1);
    chk("t3.done1", 32'(done), 32'd0);
    chk("t3.vld1",  32'(bus.out_valid), 32'd0);
    tick();
    chk("t3.busy2", 32'(busy), 32'd1);
    chk("t3.done2", 32'(done), 32'd1);
    chk("t3.vld2",  32'(bus.out_valid), 32'd0);
    tick();
    chk("t3.busy3", 32'(busy), 32'd0);
    chk("t3.done3", 32'(done), 32'd0);
    tick();
    chk("t3.done4", 32'(done), 32'd0);

    // ---- 1/1/1 with a 3-cycle downstream stall after the first beat ----
    do_start(1, 1, 1);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hB1;
    tick();
    chk_out("t4.beat1", 1'b1, 2'b11, 32'hB1);
    bus.out_ready = 1'b0;
    bus.s_data    = 32'hB2;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("t4.stall_rdy%0d", c), 32'(bus.s_ready), 32'd0);
      tick();
      chk_out($sformatf("t4.hold%0d", c), 1'b1, 2'b11, 32'hB1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("t4.rdy_resume", 32'(bus.s_ready), 32'd1);
    tick();
    chk_out("t4.beat2", 1'b1, 2'b10, 32'hB2);
    bus.s_data = 32'hB3;
    tick();
    chk_out("t4.beat3", 1'b1, 2'b01, 32'hB3);
    bus.s_valid = 1'b0;
    tick();
    chk("t4.done", 32'(done), 32'd1);
    chk_out("t4.after", 1'b0, 2'b00, 32'h0);
    tick();
    chk("t4.busy_end", 32'(busy), 32'd0);

    // ---- reset in the middle of the WGT region ----
    do_start(1, 3, 1);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hC1;
    tick();
    bus.s_data  = 32'hC2;
    tick();
    chk_out("t5.wgt1", 1'b1, 2'b10, 32'hC2);
    rst_n = 1'b0;
    #1;
    chk_out("t5.rst", 1'b0, 2'b00, 32'h0);
    chk("t5.rst_busy",    32'(busy),        32'd0);
    chk("t5.rst_done",    32'(done),        32'd0);
    chk("t5.rst_s_ready", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    chk("t5.idle_busy", 32'(busy), 32'd0);
    chk("t5.idle_done", 32'(done), 32'd0);
    do_start(1, 1, 1);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hD1;
    tick();
    chk_out("t5.new1", 1'b1, 2'b11, 32'hD1);
    bus.s_data  = 32'hD2;
    tick();
    chk_out("t5.new2", 1'b1, 2'b10, 32'hD2);
    bus.s_data  = 32'hD3;
    tick();
    chk_out("t5.new3", 1'b1, 2'b01, 32'hD3);
    bus.s_valid = 1'b0;
    tick();
    chk("t5.done", 32'(done), 32'd1);
    tick();
    chk("t5.busy_end", 32'(busy), 32'd0);

`ifdef PARAM_LOAD_SEQ_STATUS_EN
    // ---- status outputs ----
    do_start(2, 2, 1);
    chk("t6.err0", 32'(err_start), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6.err_set", 32'(err_start), 32'd1);
    bus.s_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      bus.s_data = 32'(16 + k);
      tick();
    end
    bus.s_valid = 1'b0;
    tick();
    chk("t6.done",  32'(done), 32'd1);
    chk("t6.words", 32'(words_loaded), 32'd5);
    tick();
    chk("t6.words_hold", 32'(words_loaded), 32'd5);
    chk("t6.err_sticky", 32'(err_start), 32'd1);
    do_start(0, 0, 0);
    chk("t6.err_clr",   32'(err_start), 32'd0);
    chk("t6.words_clr", 32'(words_loaded), 32'd0);
    tick();
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_load_sequencer.md
Name: param_load_sequencer

Overview:
- Front-end load controller that feeds the 1-to-3 parameter demultiplexer.
- Accepts one valid/ready word stream from the external loader and tags each word as BIAS, WGT or IFM by counting against programmed per-region lengths.
- Drives registered sel/data/valid toward the demux.
- Sequencing order: BIAS, then WGT, then IFM; then signals completion.

Parameters:
- DATA_WIDTH, 32, width of stream word and output data
- CNT_WIDTH, 16, width of region length counters (max 2^CNT_WIDTH-1 words per region)
- IFM, 2'b01, sel code for input feature map words
- WGT, 2'b10, sel code for weight words
- BIAS, 2'b11, sel code for bias words; 2'b00 means no destination

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a load; sampled only in IDLE
- num_bias  input  CNT_WIDTH  bias word count, latched on start
- num_wgt  input  CNT_WIDTH  weight word count, latched on start
- num_ifm  input  CNT_WIDTH  IFM word count, latched on start
- s_data  input  DATA_WIDTH  incoming stream word
- s_valid  input  1  s_data valid
- s_ready  output  1  sequencer accepts s_data this cycle
- out_ready  input  1  downstream buffer accepts out_data
- sel  output  2  destination code to demux
- out_data  output  DATA_WIDTH  word to demux
- out_valid  output  1  out_data/sel valid
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse at end of load

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sel=2'b00, out_data=0, out_valid=0, s_ready=0, busy=0, done=0, all counters=0.
- States: IDLE, LD_BIAS, LD_WGT, LD_IFM, DRAIN, FIN.
- IDLE: when start=1, latch the three counts and go to the first phase with a nonzero count. If all counts are 0, go to DRAIN. start is ignored outside IDLE.
- Load phases:
  - s_ready = (!out_valid || out_ready), combinational.
  - Handshake when s_valid && s_ready: out_data<=s_data, sel<=phase code, out_valid<=1, phase remaining count decrements.
  - Latency is 1 cycle from input handshake to out_valid. Throughput is 1 word/cycle.
- Phase exit: on acceptance of the last word of a phase (remaining==1), move to the next phase with a nonzero count, or to DRAIN. No bubble between phases: the next phase can accept a word on the following cycle.
- Zero-length phases are skipped entirely; their sel code never appears.
- Output hold: while out_valid=1 && out_ready=0, out_data and sel hold stable and s_ready=0.
- When out_valid=1, out_ready=1 and no new input handshake occurs that cycle: next cycle out_valid=0, sel=2'b00, out_data=0.
- DRAIN: s_ready=0. Wait until out_valid=0 or (out_valid && out_ready), then go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE. busy deasserts in the same cycle the state returns to IDLE.
- Asserting rst_n low mid-load aborts immediately. All outputs return to reset values, no done pulse, and any partially loaded region is discarded.
- Count rules: counts are unsigned; no wrap inside a phase. Max count 2^CNT_WIDTH-1 is legal.

Optional Feature:
- Macro: PARAM_LOAD_SEQ_STATUS_EN
- With macro: adds output err_start (1 bit, sticky) and output words_loaded (CNT_WIDTH+2 bits).
  - err_start is set when start=1 while busy=1, and cleared on the next accepted start in IDLE.
  - words_loaded counts output handshakes of the current load; it clears on accepted start and holds its value after done.
- Without macro: neither port exists, and start while busy is silently ignored.

Test Plan:
- Counts bias=2, wgt=3, ifm=4, s_valid and out_ready held high, data 1..9 -> sel sequence 11,11,10,10,10,01,01,01,01 on 9 consecutive out_valid cycles, out_data 1..9, done pulse 2 cycles after the last input handshake.
- Counts bias=0, wgt=2, ifm=0 -> only sel=10 appears, 2 beats, then done; no 11 or 01 ever driven.
- All counts 0 with start -> no out_valid, done pulses exactly once, busy high for 2 cycles.
- bias=1, wgt=1, ifm=1 with out_ready low for 3 cycles after the first beat -> out_data and sel held stable, s_ready=0 during the stall, no word lost or duplicated.
- Drop rst_n mid-WGT phase after 1 of 3 words -> outputs at reset values immediately; a new start with counts 1/1/1 completes normally.
- Status build (PARAM_LOAD_SEQ_STATUS_EN defined): pulse start while busy -> err_start=1. After a 5-word load, words_loaded=5 and remains 5 after done.
